// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding selects, load-use / multiply
// scoreboard / multiply structural stall detection, and a single-entry
// latency tracker for the multi-cycle multiplier.
// Optional build macro HFU_WB_BYPASS_EN: enables the WB->ID regfile bypass
// selects fwd_id_rs / fwd_id_rt (tied 0 otherwise).
module hazard_forward_unit #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_mul,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_alusrc,
   input  logic              ex_memrd,
   input  logic              ex_mul_start,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwr,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwr,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              fwd_id_rs,
   output logic              fwd_id_rt,
   output logic              stall_if_id,
   output logic              bubble_id_ex,
   output logic              mul_busy,
   output logic              mul_wb_valid,
   output logic [REG_AW-1:0] mul_wb_rd
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [REG_AW-1:0] sb_rd;
   logic              mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
   logic              ld_use_haz, sb_haz, st_haz;

   assign mem_hit_a = mem_regwr && (mem_rd != '0) && (mem_rd == ex_rs);
   assign wb_hit_a  = wb_regwr  && (wb_rd  != '0) && (wb_rd  == ex_rs);
   assign mem_hit_b = mem_regwr && (mem_rd != '0) && (mem_rd == ex_rt);
   assign wb_hit_b  = wb_regwr  && (wb_rd  != '0) && (wb_rd  == ex_rt);

   // EX operand selects; EX/MEM holds the younger value so it beats MEM/WB
   always_comb begin
      fwd_a = 2'b00;
      if (mem_hit_a)     fwd_a = 2'b10;
      else if (wb_hit_a) fwd_a = 2'b11;
      fwd_b = 2'b00;
      if (ex_alusrc)      fwd_b = 2'b01;
      else if (mem_hit_b) fwd_b = 2'b10;
      else if (wb_hit_b)  fwd_b = 2'b11;
   end

`ifdef HFU_WB_BYPASS_EN
   // Regfile writes late in the cycle, so a same-cycle WB write must bypass to ID
   assign fwd_id_rs = wb_regwr && (wb_rd != '0) && (wb_rd == id_rs) && id_uses_rs;
   assign fwd_id_rt = wb_regwr && (wb_rd != '0) && (wb_rd == id_rt) && id_uses_rt;
`else
   assign fwd_id_rs = 1'b0;
   assign fwd_id_rt = 1'b0;
`endif

   assign mul_busy     = (state == BUSY);
   assign mul_wb_valid = mul_busy && (cnt == '0);
   assign mul_wb_rd    = mul_wb_valid ? sb_rd : '0;

   // Hazard detection; sb_rd == 0 means the multiply targets r0 and blocks nothing
   always_comb begin
      ld_use_haz = ex_memrd && (ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
      sb_haz     = mul_busy && (sb_rd != '0) &&
                   ((id_uses_rs && (id_rs == sb_rd)) || (id_uses_rt && (id_rt == sb_rd)));
      st_haz     = id_is_mul && mul_busy && ((cnt != '0) || ex_mul_start);
   end

   assign stall_if_id  = ld_use_haz || sb_haz || st_haz;
   assign bubble_id_ex = stall_if_id;

   // Multiply tracker: issue from IDLE, count down, re-issue allowed only on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sb_rd <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ex_mul_start) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(MUL_LAT - 1);
                  sb_rd <= ex_rd;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  // issue while counting is illegal and dropped
                  cnt <= cnt - CNT_W'(1);
               end else if (ex_mul_start) begin
                  cnt   <= CNT_W'(MUL_LAT - 1);
                  sb_rd <= ex_rd;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Next-generation forwarding/hazard unit for the 5-stage pipeline.
- Generalises register-address width and adds load-use stall detection.
- Adds a single-entry scoreboard with a latency counter for a multi-cycle multiply unit.
- Drives ALU operand-source selects for EX and stall/bubble controls for IF/ID and ID/EX.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and never forwarded or tracked.
- MUL_LAT, 4, cycles from multiply issue in EX to result write; legal range 2..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_AW  rs of instruction in IF/ID
- id_rt  in  REG_AW  rt of instruction in IF/ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_mul  in  1  ID instruction is a multiply
- ex_rs  in  REG_AW  rs in ID/EX
- ex_rt  in  REG_AW  rt in ID/EX
- ex_rd  in  REG_AW  destination in ID/EX
- ex_alusrc  in  1  ID/EX selects immediate for ALU B
- ex_memrd  in  1  ID/EX instruction is a load
- ex_mul_start  in  1  ID/EX instruction is a multiply (issues this cycle)
- mem_rd  in  REG_AW  destination in EX/MEM
- mem_regwr  in  1  EX/MEM writes register
- wb_rd  in  REG_AW  destination in MEM/WB
- wb_regwr  in  1  MEM/WB writes register
- fwd_a  out  2  ALU A select: 00 regfile, 10 EX/MEM, 11 MEM/WB
- fwd_b  out  2  ALU B select: 00 regfile, 01 imm, 10 EX/MEM, 11 MEM/WB
- fwd_id_rs  out  1  WB→ID regfile bypass for rs (optional feature)
- fwd_id_rt  out  1  WB→ID regfile bypass for rt (optional feature)
- stall_if_id  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  load NOP into ID/EX
- mul_busy  out  1  multiply outstanding
- mul_wb_valid  out  1  one-cycle pulse: multiply result written this cycle
- mul_wb_rd  out  REG_AW  destination of completing multiply

Behaviour:

Forwarding (combinational):
- fwd_a = 10 if mem_regwr, mem_rd != 0 and mem_rd == ex_rs.
- Otherwise fwd_a = 11 if wb_regwr, wb_rd != 0 and wb_rd == ex_rs.
- Otherwise fwd_a = 00.
- fwd_b: ex_alusrc forces 01 first; otherwise the same rules as fwd_a, applied to ex_rt.
- Priority is EX/MEM over MEM/WB.

Load-use hazard (combinational):
- Asserts when ex_memrd, ex_rd != 0, and ((id_uses_rs and id_rs == ex_rd) or (id_uses_rt and id_rt == ex_rd)).

Scoreboard/FSM (registered):
- States: IDLE, BUSY.
- Registers: cnt (CNT_W bits), sb_rd (REG_AW bits).
- In IDLE, when ex_mul_start is high: go to BUSY; cnt ← MUL_LAT-1; sb_rd ← ex_rd.
- If ex_rd == 0, the multiply still occupies the unit, but sb_rd = 0 blocks no reads.
- In BUSY with cnt != 0: cnt decrements by 1 each cycle.
- In BUSY with cnt == 0: mul_wb_valid = 1 and mul_wb_rd = sb_rd, both combinational from state. Next state is IDLE, or BUSY reloaded if ex_mul_start is high in the same cycle (back-to-back issue is legal only at completion).
- mul_busy = (state == BUSY).
- Scoreboard hazard asserts when mul_busy, sb_rd != 0, and ID reads sb_rd, in any cycle including the completion cycle.
- Structural hazard asserts when id_is_mul and mul_busy, and cnt != 0 or the instruction in EX is itself a multiply.
- ex_mul_start while BUSY with cnt != 0 is illegal; it is ignored and the state is unchanged.

Stall outputs:
- stall_if_id = bubble_id_ex = load-use | scoreboard | structural hazard.

Reset (asynchronous, rst_n low):
- state = IDLE; cnt = 0; sb_rd = 0.
- mul_busy = 0 and mul_wb_valid = 0.
- Combinational outputs follow their inputs during reset.
- Reset mid-multiply discards the operation with no wb pulse.

Optional Feature:
- Macro: HFU_WB_BYPASS_EN.
- Defined: fwd_id_rs = wb_regwr & wb_rd != 0 & wb_rd == id_rs & id_uses_rs. fwd_id_rt is the same rule applied to id_rt. This covers write-then-read in the same cycle for regfiles that write on the falling edge late.
- Undefined: fwd_id_rs and fwd_id_rt are tied 0, with no extra logic.

Test Plan:
- mem_rd=3, mem_regwr=1, wb_rd=3, wb_regwr=1, ex_rs=3, ex_rt=3, ex_alusrc=1 → fwd_a=10, fwd_b=01.
- mem_rd=0, mem_regwr=1, ex_rs=0 → fwd_a=00; same with wb_rd=5, ex_rs=5 → fwd_a=11.
- ex_memrd=1, ex_rd=7, id_rt=7, id_uses_rt=1 → stall_if_id=bubble_id_ex=1 for exactly that cycle; id_uses_rt=0 → 0.
- ex_mul_start=1, ex_rd=9 at cycle 0 (MUL_LAT=4) → mul_busy=1 cycles 1–4; mul_wb_valid=1, mul_wb_rd=9 at cycle 4 only. ID reading r9 stalls cycles 1–4; ID reading r8 does not stall.
- Multiply in BUSY with cnt=2, id_is_mul=1 → stall until the completion cycle. Issue at completion reloads BUSY with no idle gap.
- Multiply issued; rst_n pulsed low at cycle 2 → mul_busy=0 immediately, no mul_wb_valid. With HFU_WB_BYPASS_EN defined: wb_rd=4, wb_regwr=1, id_rs=4, id_uses_rs=1 → fwd_id_rs=1.
